mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single unified memory port between the instruction cache (Icache) and the data cache (Dcache). Each cycle it picks one requester and forwards that command to `mem`. It routes the accepted-transaction response back only to the granted requester. It keeps a per-tag owner table so that returning load data reaches only the cache that issued it. The block sits between the two caches and the `mem` instance at the top level.

## Interface
- `STARVE_LIMIT`, default 4: consecutive denied Icache cycles before Icache is forced to win.
- `clock` input 1: system clock.
- `reset` input 1: synchronous, active-high.
- `proc2Dmem_command` input 2: Dcache command (BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2).
- `proc2Dmem_addr` input `XLEN`: Dcache address.
- `proc2Dmem_data` input 64: Dcache store data.
- `proc2Imem_command` input 2: Icache command. Icache issues only BUS_NONE or BUS_LOAD.
- `proc2Imem_addr` input `XLEN`: Icache address.
- `mem2proc_response` input 4: accepted-transaction tag from memory, same cycle; 0 means rejected.
- `mem2proc_data` input 64: returning load data.
- `mem2proc_tag` input 4: tag of the returning data; 0 means none.
- `proc2mem_command` output 2: command to memory.
- `proc2mem_addr` output `XLEN`: address to memory.
- `proc2mem_data` output 64: store data to memory.
- `Dmem2proc_response`, `Imem2proc_response` output 4: per-requester copy of `mem2proc_response`; 0 for the loser.
- `Dmem2proc_data`, `Imem2proc_data` output 64: `mem2proc_data` passed through unconditionally.
- `Dmem2proc_tag`, `Imem2proc_tag` output 4: `mem2proc_tag`, delivered only to the owner; 0 otherwise.
- `grant_icache` output 1: Icache holds the port this cycle.
- `orphan_tag_err` output 1: a nonzero `mem2proc_tag` arrived with no owner. Registered, one-cycle pulse.

## Operation
- Request: a requester is requesting when its command is not BUS_NONE.
- Arbitration is combinational.
  - Default: Dcache wins.
  - Icache wins if Dcache is idle, or if `starve_cnt == STARVE_LIMIT` (configurable; see Configuration).
- Winner's command/addr/data go to memory.
  - Icache winner: `proc2mem_data` = 0.
  - No requester: command = BUS_NONE, addr = 0, data = 0.
- `mem2proc_response` is copied only to the winner's response output. The loser's response output is 0, so the loser retries next cycle with its inputs unchanged.
- Owner table: 15 entries (tags 1..15), each holding {valid, owner}, where owner 0 = Dcache and 1 = Icache.
  - Set: a granted BUS_LOAD with nonzero `mem2proc_response` sets entry[response] = {1, winner}.
  - Stores: a granted BUS_STORE writes nothing to the table.
- Return: a nonzero `mem2proc_tag` with a valid entry drives that owner's tag output and clears the entry.
  - If the entry is invalid, both tag outputs are 0 and `orphan_tag_err` pulses the next cycle.
- Starvation counter `starve_cnt`, width clog2(STARVE_LIMIT+1):
  - increments when Icache requests and loses;
  - clears when Icache wins, or when Icache is idle.
- Same-tag collision: if a tag returns and the same tag is re-issued in the same cycle, the return is routed using the old entry, then the new set overwrites it (set wins).

## Timing
- Arbitration, forwarding and response routing are all zero-latency combinational paths.
- Owner-table updates and the counter update at posedge.
- A returned tag is routable from the cycle after the response that issued it.
- Reset values: table all invalid, `starve_cnt` = 0, `orphan_tag_err` = 0.
  - With no requests, all command/addr/data/tag/response outputs are 0 and `grant_icache` = 0.
- Reset mid-operation: the table is cleared. Tags still in flight return as orphans: they are dropped and `orphan_tag_err` pulses.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined: the starvation counter is present, and Icache is forced to win at `STARVE_LIMIT`.
- Undefined: fixed Dcache priority. The counter logic is removed and `STARVE_LIMIT` is ignored.

## Structure
- Shared package / sys_defs: BUS_NONE/BUS_LOAD/BUS_STORE, `XLEN`, `NUM_MEM_TAGS` (15), and an `ARB_OWNER` enum {OWN_DCACHE, OWN_ICACHE}.
- Sub-module `mem_tag_table`: the 15-entry owner table, with a set port and a lookup/clear port, plus the collision rule.

## Test plan
- Icache LOAD 0x100 alone, memory returns response 3: `Imem2proc_response`=3, `grant_icache`=1. Tag 3 returns with data 0xDEAD → `Imem2proc_tag`=3, `Dmem2proc_tag`=0.
- Dcache LOAD 0x810 and Icache LOAD 0x40 in the same cycle: Dcache is granted and `Imem2proc_response`=0. Icache is granted next cycle once Dcache goes idle.
- With `MEM_ARB_FAIRNESS_EN` and STARVE_LIMIT=4, both request continuously: Icache is granted on the 5th cycle, and the counter returns to 0.
- Dcache STORE 0x010 with data 0xFFFF_1234_4321_FFFF, response 5, then tag 5 returns: no table entry was written, so `orphan_tag_err`=1 next cycle and both tag outputs are 0.
- Tag 7 returns to Dcache while the same cycle's Icache LOAD gets response 7: the return goes to Dcache, and the following return of tag 7 goes to Icache.
- Reset asserted with tags 2 and 9 outstanding: both later returns are dropped, and `orphan_tag_err` pulses twice.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared bus command encodings, widths and owner type
// for the Icache/Dcache memory arbiter slice.
package mem_arbiter_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned NUM_MEM_TAGS = 15;
   localparam int unsigned TAG_W        = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } bus_cmd_e;

   typedef enum logic {
      OWN_DCACHE = 1'b0,
      OWN_ICACHE = 1'b1
   } arb_owner_e;

   typedef struct packed {
      logic       valid;
      arb_owner_e owner;
   } tag_entry_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side, memory-side and status signals of the
// arbiter. slave = arbiter view, master = surrounding environment view.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;

   logic [1:0]      proc2Dmem_command;
   logic [XLEN-1:0] proc2Dmem_addr;
   logic [63:0]     proc2Dmem_data;
   logic [1:0]      proc2Imem_command;
   logic [XLEN-1:0] proc2Imem_addr;

   logic [3:0]      mem2proc_response;
   logic [63:0]     mem2proc_data;
   logic [3:0]      mem2proc_tag;

   logic [1:0]      proc2mem_command;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0]     proc2mem_data;

   logic [3:0]      Dmem2proc_response;
   logic [63:0]     Dmem2proc_data;
   logic [3:0]      Dmem2proc_tag;
   logic [3:0]      Imem2proc_response;
   logic [63:0]     Imem2proc_data;
   logic [3:0]      Imem2proc_tag;

   logic            grant_icache;
   logic            orphan_tag_err;

   modport slave (
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  proc2Imem_command, proc2Imem_addr,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data,
      output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
      output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      output grant_icache, orphan_tag_err
   );

   modport master (
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output proc2Imem_command, proc2Imem_addr,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data,
      input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
      input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      input  grant_icache, orphan_tag_err
   );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// mem_tag_table: 15-entry owner table indexed by memory tag (1..15).
// Lookup is combinational on the current contents; a hit clears the
// entry at the clock edge unless the same tag is being set, in which
// case the new owner replaces it.
module mem_tag_table
   import mem_arbiter_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             set_en,
   input  logic [TAG_W-1:0] set_tag,
   input  arb_owner_e       set_owner,
   input  logic [TAG_W-1:0] lookup_tag,
   output logic             lookup_hit,
   output arb_owner_e       lookup_owner
);

   tag_entry_t entries [1:NUM_MEM_TAGS];

   // Read the owner of a returning tag; tag 0 never hits.
   always_comb begin
      lookup_hit   = 1'b0;
      lookup_owner = OWN_DCACHE;
      if (lookup_tag != '0) begin
         lookup_hit   = entries[lookup_tag].valid;
         lookup_owner = entries[lookup_tag].owner;
      end
   end

   // Set on issue, clear on return; set takes precedence on a tag collision.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i <= NUM_MEM_TAGS; i++) begin
            if (set_en && (set_tag == TAG_W'(i))) begin
               entries[i].valid <= 1'b1;
               entries[i].owner <= set_owner;
            end else if (lookup_hit && (lookup_tag == TAG_W'(i))) begin
               entries[i].valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified memory port between Icache and Dcache.
// Dcache has priority; Icache wins when Dcache is idle. Build option
// MEM_ARB_FAIRNESS_EN adds a starvation counter that forces an Icache
// grant after STARVE_LIMIT consecutive denied Icache cycles.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
)
(
   input  logic         clock,
   input  logic         reset,
   mem_arbiter_if.slave bus
);

   logic       d_req;
   logic       i_req;
   logic       force_icache;
   logic       grant_i;
   logic       grant_d;
   logic       load_won;
   logic       set_en;
   logic       lookup_hit;
   arb_owner_e lookup_owner;
   arb_owner_e set_owner;
   logic       orphan_q;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   // Force Icache through once it has been denied STARVE_LIMIT times in a row.
   always_comb force_icache = (starve_cnt == CNT_W'(STARVE_LIMIT));

   // Count consecutive denied Icache requests; any Icache win or idle clears.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (i_req && !grant_i) begin
         starve_cnt <= starve_cnt + 1'b1;
      end else begin
         starve_cnt <= '0;
      end
   end
`else
   logic [31:0] unused_starve_limit;
   assign unused_starve_limit = STARVE_LIMIT;

   // Fixed Dcache priority: Icache is never forced.
   always_comb force_icache = 1'b0;
`endif

   // Pick the winner and forward its command to memory.
   always_comb begin
      d_req   = (bus.proc2Dmem_command != BUS_NONE);
      i_req   = (bus.proc2Imem_command != BUS_NONE);
      grant_i = i_req && (!d_req || force_icache);
      grant_d = d_req && !grant_i;

      bus.proc2mem_command = '0;
      bus.proc2mem_addr    = '0;
      bus.proc2mem_data    = '0;
      if (grant_i) begin
         bus.proc2mem_command = bus.proc2Imem_command;
         bus.proc2mem_addr    = bus.proc2Imem_addr;
      end else if (grant_d) begin
         bus.proc2mem_command = bus.proc2Dmem_command;
         bus.proc2mem_addr    = bus.proc2Dmem_addr;
         bus.proc2mem_data    = bus.proc2Dmem_data;
      end

      bus.Dmem2proc_response = grant_d ? bus.mem2proc_response : '0;
      bus.Imem2proc_response = grant_i ? bus.mem2proc_response : '0;
      bus.grant_icache       = grant_i;

      load_won  = (grant_i && (bus.proc2Imem_command == BUS_LOAD)) ||
                  (grant_d && (bus.proc2Dmem_command == BUS_LOAD));
      set_en    = load_won && (bus.mem2proc_response != '0);
      set_owner = grant_i ? OWN_ICACHE : OWN_DCACHE;
   end

   mem_tag_table u_tag_table (
      .clock        (clock),
      .reset        (reset),
      .set_en       (set_en),
      .set_tag      (bus.mem2proc_response),
      .set_owner    (set_owner),
      .lookup_tag   (bus.mem2proc_tag),
      .lookup_hit   (lookup_hit),
      .lookup_owner (lookup_owner)
   );

   // Deliver a returning tag only to the cache that issued it.
   always_comb begin
      bus.Dmem2proc_tag = '0;
      bus.Imem2proc_tag = '0;
      if (lookup_hit) begin
         if (lookup_owner == OWN_ICACHE) begin
            bus.Imem2proc_tag = bus.mem2proc_tag;
         end else begin
            bus.Dmem2proc_tag = bus.mem2proc_tag;
         end
      end
   end

   // Flag a nonzero returning tag that nobody owns, one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         orphan_q <= 1'b0;
      end else begin
         orphan_q <= (bus.mem2proc_tag != '0) && !lookup_hit;
      end
   end

   assign bus.orphan_tag_err = orphan_q;
   assign bus.Dmem2proc_data = bus.mem2proc_data;
   assign bus.Imem2proc_data = bus.mem2proc_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test-plan scenarios plus randomized traffic,
// checked by a scoreboard against a tag-ownership reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   typedef struct {
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [63:0] data;
      logic [3:0]  dresp;
      logic [3:0]  iresp;
      logic [3:0]  dtag;
      logic [3:0]  itag;
      logic [63:0] rdata;
      logic        gi;
      logic        orphan;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   exp_t q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: who owns each outstanding tag, how long Icache
   // has been kept waiting, and whether an orphan return is pending report.
   int owner_of[int];
   int denied = 0;
   bit orphan_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         chk("proc2mem_command",   bus.proc2mem_command,   mon_e.cmd);
         chk("proc2mem_addr",      bus.proc2mem_addr,      mon_e.addr);
         chk("proc2mem_data",      bus.proc2mem_data,      mon_e.data);
         chk("Dmem2proc_response", bus.Dmem2proc_response, mon_e.dresp);
         chk("Imem2proc_response", bus.Imem2proc_response, mon_e.iresp);
         chk("Dmem2proc_tag",      bus.Dmem2proc_tag,      mon_e.dtag);
         chk("Imem2proc_tag",      bus.Imem2proc_tag,      mon_e.itag);
         chk("Dmem2proc_data",     bus.Dmem2proc_data,     mon_e.rdata);
         chk("Imem2proc_data",     bus.Imem2proc_data,     mon_e.rdata);
         chk("grant_icache",       bus.grant_icache,       mon_e.gi);
         chk("orphan_tag_err",     bus.orphan_tag_err,     mon_e.orphan);
      end
   end

   task automatic drive_idle();
      bus.proc2Dmem_command = '0;
      bus.proc2Dmem_addr    = '0;
      bus.proc2Dmem_data    = '0;
      bus.proc2Imem_command = '0;
      bus.proc2Imem_addr    = '0;
      bus.mem2proc_response = '0;
      bus.mem2proc_data     = '0;
      bus.mem2proc_tag      = '0;
   endtask

   // One cycle: drive inputs, predict outputs, advance the model.
   task automatic step(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata,
                       output bit gi, output bit gd);
      exp_t e;
      bit   dreq, ireq, force_i, hit, load_won;
      int   own;
      bus.proc2Dmem_command = dc;
      bus.proc2Dmem_addr    = da;
      bus.proc2Dmem_data    = dd;
      bus.proc2Imem_command = ic;
      bus.proc2Imem_addr    = ia;
      bus.mem2proc_response = resp;
      bus.mem2proc_tag      = rtag;
      bus.mem2proc_data     = rdata;

      dreq    = (dc != 2'd0);
      ireq    = (ic != 2'd0);
      force_i = FAIR && (denied == STARVE_LIMIT);
      gi      = ireq && (!dreq || force_i);
      gd      = dreq && !gi;

      e.cmd    = gi ? ic : (gd ? dc : 2'd0);
      e.addr   = gi ? ia : (gd ? da : 32'd0);
      e.data   = gd ? dd : 64'd0;
      e.dresp  = gd ? resp : 4'd0;
      e.iresp  = gi ? resp : 4'd0;
      e.rdata  = rdata;
      e.gi     = gi;
      e.orphan = orphan_pending;
      hit      = (rtag != 4'd0) && owner_of.exists(int'(rtag));
      own      = hit ? owner_of[int'(rtag)] : -1;
      e.dtag   = (own == 0) ? rtag : 4'd0;
      e.itag   = (own == 1) ? rtag : 4'd0;
      q.push_back(e);

      orphan_pending = (rtag != 4'd0) && !hit;
      if (hit) owner_of.delete(int'(rtag));
      load_won = (gi && ic == 2'd1) || (gd && dc == 2'd1);
      if (load_won && resp != 4'd0) owner_of[int'(resp)] = gi ? 1 : 0;
      denied = (ireq && !gi) ? denied + 1 : 0;

      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b1;
      owner_of.delete();
      denied         = 0;
      orphan_pending = 1'b0;
      @(posedge clock);
      #1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      bit          gi, gd;
      logic [1:0]  dc, ic;
      logic [31:0] da, ia;
      logic [63:0] dd;
      logic [3:0]  resp, rtag;

      drive_idle();
      do_reset();

      // Reset state: everything quiet.
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      // Icache load alone, tag 3 returns to Icache.
      step(0, 0, 0, 1, 32'h100, 4'd3, 0, 0, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd3, 64'hDEAD, gi, gd);

      // Contention: Dcache first, Icache next cycle.
      step(1, 32'h810, 0, 1, 32'h40, 4'd4, 0, 0, gi, gd);
      step(0, 0, 0, 1, 32'h40, 4'd6, 0, 0, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd4, 64'h1111, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd6, 64'h2222, gi, gd);

      // Both requesting continuously, memory rejecting.
      for (int i = 0; i < 12; i++) begin
         step(1, 32'h900, 0, 1, 32'h80, 4'd0, 0, 0, gi, gd);
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      // Store leaves no owner: its tag returns as an orphan.
      step(2, 32'h010, 64'hFFFF_1234_4321_FFFF, 0, 0, 4'd5, 0, 0, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd5, 64'h5, gi, gd);
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      // Same-tag collision: return uses old owner, new issue takes the tag.
      step(1, 32'h20, 0, 0, 0, 4'd7, 0, 0, gi, gd);
      step(0, 0, 0, 1, 32'h30, 4'd7, 4'd7, 64'h77, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd7, 64'h78, gi, gd);
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      // Reset with tags 2 and 9 outstanding: both return as orphans.
      step(0, 0, 0, 1, 32'h200, 4'd2, 0, 0, gi, gd);
      step(1, 32'h300, 0, 0, 0, 4'd9, 0, 0, gi, gd);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 4'd2, 64'h2, gi, gd);
      step(0, 0, 0, 0, 0, 0, 4'd9, 64'h9, gi, gd);
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      // Randomized traffic; a losing requester holds its command.
      dc = 2'($urandom_range(0, 2));
      da = $urandom;
      dd = {$urandom, $urandom};
      ic = 2'($urandom_range(0, 1));
      ia = $urandom;
      for (int i = 0; i < 600; i++) begin
         resp = ((dc != 0) || (ic != 0)) ? 4'($urandom_range(0, 15)) : 4'd0;
         rtag = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
         step(dc, da, dd, ic, ia, resp, rtag, {$urandom, $urandom}, gi, gd);
         if (gd || dc == 2'd0) begin
            dc = 2'($urandom_range(0, 2));
            da = $urandom;
            dd = {$urandom, $urandom};
         end
         if (gi || ic == 2'd0) begin
            ic = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'd0;
            ia = $urandom;
         end
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, gi, gd);

      @(negedge clock);
      #1;
      if (q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
